// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: single-cycle ALU results take priority over a small
// FIFO of long-latency LSU results; also tracks registers with writes still in flight.
module wb_arbiter #(
   parameter int LSU_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alu_valid,
   input  logic [4:0]                   alu_rd,
   input  logic [31:0]                  alu_data,
   input  logic                         lsu_valid,
   output logic                         lsu_ready,
   input  logic [4:0]                   lsu_rd,
   input  logic [31:0]                  lsu_data,
   input  logic                         pend_set,
   input  logic [4:0]                   pend_rd,
   input  logic [4:0]                   chk_addr1,
   input  logic [4:0]                   chk_addr2,
   output logic                         busy1,
   output logic                         busy2,
   output logic                         rf_we,
   output logic [4:0]                   rf_waddr,
   output logic [31:0]                  rf_wdata,
   output logic [$clog2(LSU_DEPTH):0]   lsu_count
);

   localparam int AW = $clog2(LSU_DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]    mem_rd   [LSU_DEPTH];
   logic [31:0]   mem_data [LSU_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg, count_next;
   logic [31:0]   pending_reg, pending_next;
   logic          full, push, pop;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;

   // Readiness comes from registered occupancy only, so a same-cycle pop never frees a slot.
   assign full      = (count_reg == CW'(LSU_DEPTH));
   assign lsu_ready = !full;
   assign push      = lsu_valid && !full;
   assign pop       = !alu_valid && (count_reg != '0);
   assign head_rd   = mem_rd[rd_ptr_reg];
   assign head_data = mem_data[rd_ptr_reg];
   assign lsu_count = count_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_rd[wr_ptr_reg]   <= lsu_rd;
         mem_data[wr_ptr_reg] <= lsu_data;
      end
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   // Clear from the popped entry is applied first so a coincident set on the same bit survives.
   always_comb begin
      pending_next = pending_reg;
      if (pop)
         pending_next[head_rd] = 1'b0;
      if (pend_set && (pend_rd != 5'd0))
         pending_next[pend_rd] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         pending_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg   <= count_next;
         pending_reg <= pending_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= 5'd0;
         rf_wdata <= 32'd0;
      end else if (alu_valid) begin
         rf_we <= (alu_rd != 5'd0);
         if (alu_rd != 5'd0) begin
            rf_waddr <= alu_rd;
            rf_wdata <= alu_data;
         end
      end else if (pop) begin
         rf_we <= (head_rd != 5'd0);
         if (head_rd != 5'd0) begin
            rf_waddr <= head_rd;
            rf_wdata <= head_data;
         end
      end else begin
         rf_we <= 1'b0;
      end
   end

   assign busy1 = (chk_addr1 != 5'd0) && pending_reg[chk_addr1];
   assign busy2 = (chk_addr2 != 5'd0) && pending_reg[chk_addr2];

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter LSU_DEPTH, default 2, meaning LSU result buffer entries (power of two, >=2).
REQ-002 SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 alu_valid  input  1  single-cycle ALU result present this cycle; no backpressure.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 lsu_valid  input  1  long-latency (load/mul) result offered.
REQ-009 lsu_ready  output  1  buffer can accept an LSU result; equals !full.
REQ-010 lsu_rd  input  5  LSU destination register.
REQ-011 lsu_data  input  32  LSU result.
REQ-012 pend_set  input  1  issue stage dispatched a long-latency op this cycle.
REQ-013 pend_rd  input  5  destination of that op.
REQ-014 chk_addr1, chk_addr2  input  5 each  issue-stage source registers to check.
REQ-015 busy1, busy2  output  1 each  source register has a pending long-latency write.
REQ-016 rf_we, rf_waddr, rf_wdata  output  1/5/32  regfile write port.
REQ-017 lsu_count  output  $clog2(LSU_DEPTH)+1  current buffer occupancy.

Function
REQ-018 LSU handshake SHALL complete on a rising edge with lsu_valid && lsu_ready; the entry (rd, data) is pushed at the FIFO tail.
REQ-019 lsu_ready SHALL depend only on occupancy: a push is refused when full, even if a pop occurs that cycle.
REQ-020 Arbitration SHALL be fixed priority: alu_valid wins; the FIFO head pops only in a cycle with alu_valid=0 and count>0.
REQ-021 The selected result SHALL appear on rf_* registered, one cycle after selection (ALU result at edge N drives rf_* during cycle N+1).
REQ-022 rf_we SHALL be 1 only in cycles following a selection whose rd != 0; rd==0 results are consumed (popped or accepted) but write nothing.
REQ-023 When rf_we=0, rf_waddr/rf_wdata SHALL hold their previous values.
REQ-024 A result pushed at edge N SHALL NOT pop before edge N+1 (no same-cycle push-to-pop bypass).
REQ-025 Simultaneous push and pop with count>0 and not full SHALL leave count unchanged, preserve FIFO order, and wrap pointers modulo LSU_DEPTH.
REQ-026 Scoreboard: a 32-bit pending vector; pend_set with pend_rd != 0 SHALL set bit pend_rd at the edge; pend_rd==0 is ignored.
REQ-027 A pop of an LSU entry SHALL clear pending[rd] at the same edge the entry is selected.
REQ-028 Simultaneous set and clear of the same bit SHALL leave it set (set wins).
REQ-029 busy1/busy2 SHALL be combinational: pending[chk_addrN], forced 0 when chk_addrN == 0.
REQ-030 ALU results SHALL neither set nor clear pending bits.

Reset
REQ-031 While rst=1: FIFO empty, lsu_count=0, lsu_ready=1, pending=0, busy1=busy2=0, rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries and pending bits immediately, without completing any write.
REQ-033 The first handshake SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-034 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF at edge N -> rf_we=1, waddr=5, wdata=0xDEADBEEF in cycle N+1; rf_we=0 in N+2 if idle.
REQ-035 Contention: hold alu_valid=1 for 4 cycles while pushing LSU rd=7 and rd=8 -> lsu_count reaches 2, lsu_ready=0, third push refused; after ALU stops, rd=7 then rd=8 written on consecutive cycles, in order.
REQ-036 Scoreboard: pend_set rd=9, then chk_addr1=9 -> busy1=1; LSU rd=9 popped at edge M -> busy1=0 from cycle M+1; with pend_set rd=9 at edge M, busy1 stays 1.
REQ-037 x0 handling: LSU result rd=0 pops with rf_we=0; pend_set rd=0 leaves busy=0 for chk_addr=0.
REQ-038 Wrap: LSU_DEPTH=2, 6 back-to-back pushes interleaved with pops at count 1 -> all 6 written in order, count never exceeds 2.
REQ-039 Reset mid-run: rst pulsed with count=2 and pending bits set -> count=0, lsu_ready=1, busy=0, rf_we=0 immediately; buffered entries never written.
